// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions: word layout, field helpers and
// overflow-policy encoding used by the adder/subtractor pipeline.
package sm_pkg;

  localparam int unsigned SM_MAG_W = 4;

  // Sign bit sits directly above the unsigned magnitude.
  typedef logic [SM_MAG_W:0] sm_word_t;

  typedef enum logic {
    SM_WRAP = 1'b0,
    SM_SAT  = 1'b1
  } sm_ovf_pol_e;

  function automatic logic sm_sign(input sm_word_t w);
    return w[SM_MAG_W];
  endfunction

  function automatic logic [SM_MAG_W-1:0] sm_mag(input sm_word_t w);
    return w[SM_MAG_W-1:0];
  endfunction

  function automatic sm_word_t sm_pack(input logic s, input logic [SM_MAG_W-1:0] m);
    return {s, m};
  endfunction

endpackage

// File: rtl/sm_mag_cmp.sv
// Combinational magnitude compare/swap: orders two magnitudes so the
// arithmetic stage can always subtract small from big.
module sm_mag_cmp #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_mag_i,
  input  logic [W-1:0] b_mag_i,
  output logic [W-1:0] big_o,
  output logic [W-1:0] small_o,
  output logic         a_ge_b_o
);

  // Ties resolve to A as the larger operand.
  always_comb begin
    a_ge_b_o = (a_mag_i >= b_mag_i);
    big_o    = a_ge_b_o ? a_mag_i : b_mag_i;
    small_o  = a_ge_b_o ? b_mag_i : a_mag_i;
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready on both sides,
// selectable saturate/wrap overflow, -0 normalisation and an overflow counter.
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int unsigned MAG_W = SM_MAG_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  input  logic             op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   res,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  logic             s2_adv;
  logic             s1_adv;

  logic [MAG_W-1:0] a_mag, b_mag;
  logic             sa, sb_eff, a_ge_b;
  logic [MAG_W-1:0] big_d, small_d;
  logic             sign_d, sub_d;

  logic             s1_valid_q;
  logic [MAG_W-1:0] big_q, small_q;
  logic             sign_q, sub_q;
  sm_ovf_pol_e      pol_q;

  logic [MAG_W:0]   sum;
  logic [MAG_W-1:0] mag_d;
  logic             ovf_d;
  logic [MAG_W:0]   res_d;

  logic             out_valid_q;
  logic [MAG_W:0]   res_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign sa     = a[MAG_W];
  assign sb_eff = b[MAG_W] ^ op;
  assign a_mag  = a[MAG_W-1:0];
  assign b_mag  = b[MAG_W-1:0];

  sm_mag_cmp #(.W(MAG_W)) u_cmp (
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .big_o    (big_d),
    .small_o  (small_d),
    .a_ge_b_o (a_ge_b)
  );

  // Different effective signs subtract; the result takes the larger operand's sign.
  always_comb begin
    sub_d  = sa ^ sb_eff;
    sign_d = (!sub_d || a_ge_b) ? sa : sb_eff;
  end

  // S1: capture ordered magnitudes and control on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      big_q      <= '0;
      small_q    <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      pol_q      <= SM_WRAP;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        big_q   <= big_d;
        small_q <= small_d;
        sign_q  <= sign_d;
        sub_q   <= sub_d;
        pol_q   <= sm_ovf_pol_e'(sat_en);
      end
    end
  end

  // S2 arithmetic: add with carry-out overflow or subtract, then clear -0.
  always_comb begin
    sum   = {1'b0, big_q} + {1'b0, small_q};
    mag_d = '0;
    ovf_d = 1'b0;
    if (sub_q) begin
      mag_d = big_q - small_q;
    end else begin
      ovf_d = sum[MAG_W];
      if (ovf_d && pol_q == SM_SAT) mag_d = '1;
      else                          mag_d = sum[MAG_W-1:0];
    end
    res_d = {(mag_d != '0) && sign_q, mag_d};
  end

  // S2: output register, holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // Overflow event counter: clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid_q && out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe at MAG_W=4, CNT_W=8.
module tb_sm_addsub_pipe;
  import sm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a, b;
  logic       op, sat_en;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] res;
  logic       ovf;
  logic [7:0] ovf_cnt;
  logic       cnt_clr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sm_addsub_pipe #(.MAG_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operand pair at a negedge, verify out_valid timing and result.
  // Returns at the negedge where the result is presented (handshake at next edge).
  task automatic run_op(input string tag, input logic [4:0] ta, input logic [4:0] tb_,
                        input logic top, input logic tsat,
                        input logic [4:0] eres, input logic eovf);
    a = ta; b = tb_; op = top; sat_en = tsat; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".res"}, res, eres);
    check({tag, ".ovf"}, ovf, eovf);
  endtask

  logic [4:0] cap_a [4];
  logic [4:0] cap_e [4];
  logic [4:0] str_e [3];
  int unsigned acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.res", res, 0);
    check("rst.ovf", ovf, 0);
    check("rst.cnt", ovf_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic arithmetic
    run_op("add5p3", sm_pack(0, 4'd5), sm_pack(0, 4'd3), 0, 0, 5'b01000, 0);
    run_op("add9p9w", sm_pack(0, 4'd9), sm_pack(0, 4'd9), 0, 0, 5'b00010, 1);
    run_op("add9p9s", sm_pack(0, 4'd9), sm_pack(0, 4'd9), 0, 1, 5'b01111, 1);
    @(negedge clk);
    check("cnt_after2", ovf_cnt, 2);
    check("idle_valid", out_valid, 0);
    run_op("p3m7", sm_pack(0, 4'd3), sm_pack(1, 4'd7), 0, 0, 5'b10100, 0);
    run_op("p5sub5", sm_pack(0, 4'd5), sm_pack(0, 4'd5), 1, 0, 5'b00000, 0);
    run_op("negzero", sm_pack(1, 4'd0), sm_pack(1, 4'd0), 0, 0, 5'b00000, 0);
    run_op("n6subn2", sm_pack(1, 4'd6), sm_pack(1, 4'd2), 1, 0, 5'b10100, 0);
    run_op("p2m6", sm_pack(0, 4'd2), sm_pack(1, 4'd6), 0, 1, 5'b10100, 0);
    run_op("p8subn8w", sm_pack(0, 4'd8), sm_pack(1, 4'd8), 1, 0, 5'b00000, 1);
    @(negedge clk);
    check("cnt_after3", ovf_cnt, 3);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    cap_a[0] = sm_pack(0, 4'd1); cap_e[0] = 5'b00010;
    cap_a[1] = sm_pack(0, 4'd2); cap_e[1] = 5'b00100;
    cap_a[2] = sm_pack(0, 4'd3); cap_e[2] = 5'b00110;
    cap_a[3] = sm_pack(0, 4'd4); cap_e[3] = 5'b01000;
    out_ready = 1'b0; op = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    acc = 0;
    a = cap_a[0]; b = cap_a[0];
    for (int i = 0; i < 4; i++) begin
      if (in_ready) acc++;
      @(negedge clk);
      a = cap_a[acc]; b = cap_a[acc];
    end
    check("bp.accepts", acc, 2);
    check("bp.in_ready", in_ready, 0);
    check("bp.hold_valid", out_valid, 1);
    check("bp.hold_res", res, cap_e[0]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.second_valid", out_valid, 1);
    check("bp.second_res", res, cap_e[1]);
    @(negedge clk);
    check("bp.drained", out_valid, 0);

    // Back-to-back stream: one result per cycle
    str_e[0] = 5'b00111; str_e[1] = 5'b10001; str_e[2] = 5'b01011;
    for (int j = 0; j < 5; j++) begin
      case (j)
        0: begin a = sm_pack(0, 4'd4); b = sm_pack(0, 4'd3); op = 0; in_valid = 1; end
        1: begin a = sm_pack(0, 4'd4); b = sm_pack(0, 4'd5); op = 1; in_valid = 1; end
        2: begin a = sm_pack(1, 4'd2); b = sm_pack(1, 4'd13); op = 1; in_valid = 1; end
        default: in_valid = 0;
      endcase
      if (j < 3) check($sformatf("stream.in_ready%0d", j), in_ready, 1);
      if (j >= 2) begin
        check($sformatf("stream.valid%0d", j - 2), out_valid, 1);
        check($sformatf("stream.res%0d", j - 2), res, str_e[j - 2]);
      end
      @(negedge clk);
    end
    check("stream.res2", res, str_e[2]);
    @(negedge clk);
    check("stream.done", out_valid, 0);

    // Counter saturation and clear
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr_idle", ovf_cnt, 0);
    a = sm_pack(0, 4'd9); b = sm_pack(0, 4'd9); op = 0; sat_en = 1; in_valid = 1;
    repeat (255) @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    check("cnt_255", ovf_cnt, 255);
    run_op("sat_more", sm_pack(0, 4'd15), sm_pack(0, 4'd1), 0, 0, 5'b00000, 1);
    @(negedge clk);
    check("cnt_stays255", ovf_cnt, 255);
    run_op("clr_ovf", sm_pack(0, 4'd15), sm_pack(0, 4'd15), 0, 1, 5'b01111, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr_wins", ovf_cnt, 0);
    check("clr_consumed", out_valid, 0);

    // Reset with two results in flight
    run_op("pre_rst", sm_pack(0, 4'd10), sm_pack(0, 4'd10), 0, 0, 5'b00100, 1);
    @(negedge clk);
    check("pre_rst_cnt", ovf_cnt, 1);
    out_ready = 1'b0; a = sm_pack(0, 4'd1); b = sm_pack(0, 4'd1); op = 0; in_valid = 1;
    repeat (2) @(negedge clk);
    in_valid = 0;
    check("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.cnt", ovf_cnt, 0);
    check("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("postrst.no_stale%0d", k), out_valid, 0);
    end
    run_op("postrst", sm_pack(1, 4'd7), sm_pack(0, 4'd2), 0, 0, 5'b10101, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
